// File: rtl/return_address_stack.sv
// return_address_stack: circular call/return stack feeding the PC-select mux.
// Top entry is combinational from registered state for zero-latency RET.
module return_address_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int WRAP   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_data,
    input  logic                     clr_err,
    output logic [ADDR_W-1:0]        top_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     sp_q, sp_d, top_idx, wr_idx;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              we;

    assign top_idx   = sp_q - 1'b1;
    assign empty     = count_q == '0;
    assign full      = count_q == CW'(DEPTH);
    assign top_data  = empty ? '0 : mem_q[top_idx];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // New errors are applied after the clear so they win in the same cycle.
    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        we          = 1'b0;
        wr_idx      = sp_q;
        if (push && pop) begin
            we = 1'b1;
            if (empty) begin
                sp_d        = sp_q + 1'b1;
                count_d     = CW'(1);
                underflow_d = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (!full) begin
                we      = 1'b1;
                sp_d    = sp_q + 1'b1;
                count_d = count_q + 1'b1;
            end else if (WRAP != 0) begin
                we   = 1'b1;
                sp_d = sp_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                sp_d    = sp_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (we && rst) mem_q[wr_idx] <= push_data;
    end
endmodule
